// File: rtl/ibex_icache_stub_pkg.sv
// Shared types and constants for the cacheless icache stand-in.
package ibex_icache_stub_pkg;
    typedef enum logic [1:0] {SEL_NONE, SEL_SKID, SEL_JOIN, SEL_WORD} out_sel_e;

    localparam logic [1:0] COMPRESSED_MASK = 2'b11;
    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form over bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic is_compressed(logic [15:0] half);
        return (half[1:0] & COMPRESSED_MASK) != COMPRESSED_MASK;
    endfunction
endpackage

// File: rtl/ibex_icache_stub_responder_if.sv
// Instruction-bus handshake between the fetch stub (master) and memory (slave).
interface ibex_icache_stub_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ibex_icache_stub_lfsr.sv
// Free-running 8-bit stall LFSR; only instantiated with ICACHE_STUB_LFSR_STALL_EN.
module ibex_icache_stub_lfsr
    import ibex_icache_stub_pkg::*;
#(
    parameter logic [7:0] Seed = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr_o
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_o <= Seed;
        else        lfsr_o <= {lfsr_o[6:0], ^(lfsr_o & LFSR_TAPS)};
    end
endmodule

// File: rtl/ibex_icache_stub_responder.sv
// Cacheless icache stand-in: word fetches on the instr bus, 16-bit aligned instruction output.
// Optional random stalls on new instructions with ICACHE_STUB_LFSR_STALL_EN.
module ibex_icache_stub_responder
    import ibex_icache_stub_pkg::*;
#(
    parameter int unsigned BusWidth  = 32,
    parameter int unsigned InvCycles = 4,
    parameter logic [7:0]  LfsrSeed  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic        branch_spec_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        err_plus2_o,
    input  logic        enable_i,
    input  logic        invalidate_i,
    output logic        busy_o,
    ibex_icache_stub_responder_if.master instr
);
    localparam int InvW = $clog2(InvCycles + 1);

    logic                has_addr_q, has_addr_d;
    logic [31:1]         pc_q, pc_d;
    logic [31:2]         fetch_q, fetch_d, req_addr_q, req_addr_d;
    logic                outst_q, outst_d, discard_q, discard_d;
    logic                req_q, req_d, stale_q, stale_d;
    logic [BusWidth-1:0] word_q, word_d;
    logic                word_err_q, word_err_d, word_vld_q, word_vld_d;
    logic [15:0]         skid_q, skid_d;
    logic                skid_err_q, skid_err_d, skid_vld_q, skid_vld_d;
    logic [InvW-1:0]     inv_cnt;
    out_sel_e            sel;
    logic                split, cand, accept, comp_out, word_free, issue, gnt_fire;
    logic                unused_in;

    assign unused_in = ^{branch_spec_i, enable_i, branch_addr_i[0]};

    always_comb begin
        sel = SEL_NONE;
        if (skid_vld_q && (skid_err_q || is_compressed(skid_q))) sel = SEL_SKID;
        else if (skid_vld_q && word_vld_q)                      sel = SEL_JOIN;
        else if (!skid_vld_q && word_vld_q && !pc_q[1])         sel = SEL_WORD;
    end
    // Upper half of a fresh word when the PC points there: shift it into the skid first.
    assign split = !skid_vld_q && word_vld_q && pc_q[1];

    always_comb begin
        rdata_o     = word_q[31:0];
        err_o       = word_err_q;
        err_plus2_o = 1'b0;
        case (sel)
            SEL_SKID: begin
                rdata_o = {16'h0, skid_q};
                err_o   = skid_err_q;
            end
            SEL_JOIN: begin
                rdata_o     = {word_q[15:0], skid_q};
                err_o       = skid_err_q | word_err_q;
                err_plus2_o = word_err_q & ~skid_err_q;
            end
            default: ;
        endcase
    end
    assign addr_o   = {pc_q, 1'b0};
    assign cand     = has_addr_q && (sel != SEL_NONE);
    assign comp_out = is_compressed(rdata_o[15:0]);

`ifdef ICACHE_STUB_LFSR_STALL_EN
    logic [7:0] lfsr;
    logic       shown_q;
    logic       unused_lfsr;
    ibex_icache_stub_lfsr #(.Seed(LfsrSeed)) u_lfsr (.clk(clk), .rst_n(rst_n), .lfsr_o(lfsr));
    assign unused_lfsr = ^lfsr[7:1];
    // Once shown, an instruction stays up regardless of the LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shown_q <= 1'b0;
        else        shown_q <= valid_o & ~ready_i & ~branch_i;
    end
    assign valid_o = cand & (shown_q | ~lfsr[0]);
`else
    logic [7:0] unused_seed;
    assign unused_seed = LfsrSeed;
    assign valid_o     = cand;
`endif

    assign accept    = valid_o & ready_i & ~branch_i;
    assign word_free = split | (accept & ((sel == SEL_JOIN) | (sel == SEL_WORD)));
    assign issue     = req_i & has_addr_q & ~outst_q & ~req_q & ~branch_i &
                       (~word_vld_q | word_free) & ~(accept & err_o);
    assign instr.req  = req_q | issue;
    assign instr.addr = req_q ? {req_addr_q, 2'b00} : {fetch_q, 2'b00};
    assign gnt_fire   = instr.req & instr.gnt;
    assign busy_o     = outst_q | (inv_cnt != '0);

    always_comb begin
        has_addr_d = has_addr_q;  pc_d       = pc_q;       fetch_d    = fetch_q;
        outst_d    = outst_q;     discard_d  = discard_q;  req_d      = req_q;
        req_addr_d = req_addr_q;  stale_d    = stale_q;    word_d     = word_q;
        word_err_d = word_err_q;  word_vld_d = word_vld_q; skid_d     = skid_q;
        skid_err_d = skid_err_q;  skid_vld_d = skid_vld_q;
        if (instr.rvalid) begin
            outst_d   = 1'b0;
            discard_d = 1'b0;
            if (!discard_q && !branch_i) begin
                word_d     = instr.rdata;
                word_err_d = instr.err;
                word_vld_d = 1'b1;
            end
        end
        if (issue && !instr.gnt) begin
            req_d      = 1'b1;
            req_addr_d = fetch_q;
        end
        // A request raised before a branch is stale: its data is dropped, fetch_q already retargeted.
        if (gnt_fire) begin
            outst_d   = 1'b1;
            req_d     = 1'b0;
            stale_d   = 1'b0;
            discard_d = stale_q | branch_i;
            if (!stale_q) fetch_d = fetch_q + 30'd1;
        end
        if (accept) begin
            case (sel)
                SEL_SKID: begin
                    skid_vld_d = 1'b0;
                    pc_d       = pc_q + (comp_out ? 31'd1 : 31'd2);
                end
                SEL_JOIN: begin
                    skid_d     = word_q[31:16];
                    skid_err_d = word_err_q;
                    word_vld_d = 1'b0;
                    pc_d       = pc_q + 31'd2;
                end
                SEL_WORD: begin
                    word_vld_d = 1'b0;
                    pc_d       = pc_q + (comp_out ? 31'd1 : 31'd2);
                    if (comp_out) begin
                        skid_d     = word_q[31:16];
                        skid_err_d = word_err_q;
                        skid_vld_d = 1'b1;
                    end
                end
                default: ;
            endcase
            if (err_o) has_addr_d = 1'b0;
        end
        if (split) begin
            skid_d     = word_q[31:16];
            skid_err_d = word_err_q;
            skid_vld_d = 1'b1;
            word_vld_d = 1'b0;
        end
        if (branch_i) begin
            pc_d       = branch_addr_i[31:1];
            fetch_d    = branch_addr_i[31:2];
            word_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            has_addr_d = 1'b1;
            if (outst_q && !instr.rvalid) discard_d = 1'b1;
            if (req_q && !instr.gnt)      stale_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_addr_q <= 1'b0;  pc_q       <= '0;    fetch_q    <= '0;
            outst_q    <= 1'b0;  discard_q  <= 1'b0;  req_q      <= 1'b0;
            req_addr_q <= '0;    stale_q    <= 1'b0;  word_q     <= '0;
            word_err_q <= 1'b0;  word_vld_q <= 1'b0;  skid_q     <= '0;
            skid_err_q <= 1'b0;  skid_vld_q <= 1'b0;  inv_cnt    <= '0;
        end else begin
            has_addr_q <= has_addr_d;  pc_q       <= pc_d;       fetch_q    <= fetch_d;
            outst_q    <= outst_d;     discard_q  <= discard_d;  req_q      <= req_d;
            req_addr_q <= req_addr_d;  stale_q    <= stale_d;    word_q     <= word_d;
            word_err_q <= word_err_d;  word_vld_q <= word_vld_d; skid_q     <= skid_d;
            skid_err_q <= skid_err_d;  skid_vld_q <= skid_vld_d;
            if (invalidate_i)        inv_cnt <= InvW'(InvCycles);
            else if (inv_cnt != '0)  inv_cnt <= inv_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_ibex_icache_stub_responder.sv
// Bench for ibex_icache_stub_responder: directed vectors, corner sequences, random stream vs. model.
module tb_ibex_icache_stub_responder;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_i = 0, branch_i = 0, branch_spec_i = 0, ready_i = 0, enable_i = 0, invalidate_i = 0;
    logic [31:0] branch_addr_i = 0;
    logic        valid_o, err_o, err_plus2_o, busy_o;
    logic [31:0] rdata_o, addr_o;

    ibex_icache_stub_responder_if bus();

    ibex_icache_stub_responder dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .branch_spec_i(branch_spec_i),
        .branch_addr_i(branch_addr_i), .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o),
        .addr_o(addr_o), .err_o(err_o), .err_plus2_o(err_plus2_o), .enable_i(enable_i),
        .invalidate_i(invalidate_i), .busy_o(busy_o), .instr(bus)
    );

    int          errors = 0, checks = 0;
    logic [31:0] mem_w [256];
    logic        mem_e [256];
    int          gnt_pct = 100, min_dly = 0, max_dly = 0, pend_dly = 0;
    logic        pend = 0;
    logic [31:0] pend_addr = 0;
    logic [31:0] glog [$];

    function automatic int idx(logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: grant decided after inputs settle, grants logged, responses delivered at negedge.
    task automatic step();
        logic        held;
        logic [31:0] haddr;
        #1 bus.gnt = bus.req && ($urandom_range(1, 100) <= gnt_pct);
        #3;
        if (bus.req && bus.gnt && rst_n) begin
            pend = 1; pend_dly = $urandom_range(min_dly, max_dly); pend_addr = bus.addr;
            glog.push_back(bus.addr);
        end
        held  = bus.req && !bus.gnt && rst_n;
        haddr = bus.addr;
        @(negedge clk);
        if (pend && pend_dly == 0) begin
            bus.rvalid = 1; bus.rdata = mem_w[idx(pend_addr)]; bus.err = mem_e[idx(pend_addr)]; pend = 0;
        end else begin
            bus.rvalid = 0;
            if (pend) pend_dly--;
        end
        if (held) begin
            chk("req_hold", {31'd0, bus.req}, 32'd1);
            chk("req_addr_hold", bus.addr, haddr);
        end
    endtask

    task automatic branch_to(logic [31:0] a);
        branch_i = 1; branch_addr_i = a;
        step();
        branch_i = 0;
        glog.delete();
    endtask

    task automatic wait_valid(string n);
        for (int i = 0; i < 60 && !valid_o; i++) step();
        chk({n, "_timeout"}, {31'd0, valid_o}, 32'd1);
    endtask

    // Instruction at pc derived from memory halfwords.
    task automatic model(input logic [31:0] pc, output logic [31:0] d, output logic [31:0] m,
                         output logic e, output logic p, output logic [31:0] len);
        logic [31:0] wl, wh;
        logic [15:0] lo, hi;
        wl = mem_w[idx(pc)];       lo = pc[1] ? wl[31:16] : wl[15:0];
        wh = mem_w[idx(pc + 2)];   hi = pc[1] ? wh[15:0]  : wh[31:16];
        if (mem_e[idx(pc)] || lo[1:0] != 2'b11) begin
            d = {16'h0, lo}; m = 32'h0000FFFF; e = mem_e[idx(pc)]; p = 0; len = 2;
        end else begin
            d = {hi, lo}; m = 32'hFFFFFFFF; e = mem_e[idx(pc + 2)]; p = e; len = 4;
        end
    endtask

    typedef struct {
        logic [31:0] ba, w0; logic e0; logic [31:0] w1; logic e1;
        logic [31:0] ex_addr, ex_data, ex_mask; logic ex_err, ex_p2;
        int ex_n; logic [31:0] g0, g1;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [31:0] a0, d0, ed, em, el;
        logic        ee, ep, seen, done, ph;
        int          cnt, acc;
        logic [31:0] pa, pd;

        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0; bus.err = 0;
        for (int i = 0; i < 256; i++) begin mem_w[i] = 0; mem_e[i] = 0; end
        vecs[0] = '{32'h100, 32'h00000013, 0, 32'h00000093, 0, 32'h100, 32'h00000013, 32'hFFFFFFFF, 0, 0, 2, 32'h100, 32'h104};
        vecs[1] = '{32'h102, 32'h00010000, 0, 32'h00000001, 0, 32'h102, 32'h00000001, 32'h0000FFFF, 0, 0, 2, 32'h100, 32'h104};
        vecs[2] = '{32'h106, 32'h00030000, 0, 32'h12345678, 1, 32'h106, 32'h56780003, 32'hFFFFFFFF, 1, 1, 2, 32'h104, 32'h108};
        vecs[3] = '{32'h300, 32'h00058001, 0, 32'h00000013, 0, 32'h300, 32'h00008001, 32'h0000FFFF, 0, 0, 2, 32'h300, 32'h304};
        vecs[4] = '{32'h400, 32'hDEADBEEF, 1, 32'h00000013, 0, 32'h400, 32'h0000BEEF, 32'h0000FFFF, 1, 0, 1, 32'h400, 32'h0};

        repeat (3) step();
        chk("rst_valid", {31'd0, valid_o}, 0);       chk("rst_err", {31'd0, err_o}, 0);
        chk("rst_plus2", {31'd0, err_plus2_o}, 0);   chk("rst_req", {31'd0, bus.req}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);         chk("rst_rdata", rdata_o, 0);
        chk("rst_addr", addr_o, 0);                  chk("rst_iaddr", bus.addr, 0);
        rst_n = 1; req_i = 1;
        step();

        for (int v = 0; v < 5; v++) begin
            mem_w[idx(vecs[v].ba)] = vecs[v].w0;     mem_e[idx(vecs[v].ba)] = vecs[v].e0;
            mem_w[idx(vecs[v].ba + 4)] = vecs[v].w1; mem_e[idx(vecs[v].ba + 4)] = vecs[v].e1;
            ready_i = 0;
            branch_to(vecs[v].ba);
            wait_valid($sformatf("v%0d", v));
            chk($sformatf("v%0d_addr", v), addr_o, vecs[v].ex_addr);
            chk($sformatf("v%0d_rdata", v), rdata_o & vecs[v].ex_mask, vecs[v].ex_data);
            chk($sformatf("v%0d_err", v), {31'd0, err_o}, {31'd0, vecs[v].ex_err});
            chk($sformatf("v%0d_plus2", v), {31'd0, err_plus2_o}, {31'd0, vecs[v].ex_p2});
            ready_i = 1; step(); ready_i = 0;
            repeat (8) step();
            chk($sformatf("v%0d_nfetch", v), glog.size(), vecs[v].ex_n);
            if (glog.size() > 0) chk($sformatf("v%0d_fetch0", v), glog[0], vecs[v].g0);
            if (vecs[v].ex_n > 1 && glog.size() > 1) chk($sformatf("v%0d_fetch1", v), glog[1], vecs[v].g1);
        end

        // Responses in flight across branches must never surface.
        mem_w[idx(32'h600)] = 32'h33330013; mem_w[idx(32'h500)] = 32'h11110013; mem_w[idx(32'h200)] = 32'h22220013;
        mem_e[idx(32'h600)] = 0; mem_e[idx(32'h500)] = 0; mem_e[idx(32'h200)] = 0;
        min_dly = 1; max_dly = 1; seen = 0;
        branch_to(32'h600);
        for (int i = 0; i < 20 && glog.size() == 0; i++) begin seen |= valid_o; step(); end
        seen |= valid_o;
        branch_to(32'h500);
        for (int i = 0; i < 20 && glog.size() == 0; i++) begin seen |= valid_o; step(); end
        for (int i = 0; i < 20 && !bus.rvalid; i++) begin seen |= valid_o; step(); end
        chk("t4_rvalid_seen", {31'd0, bus.rvalid}, 1);
        branch_to(32'h200);
        wait_valid("t4");
        chk("t4_no_stale", {31'd0, seen}, 0);
        chk("t4_addr", addr_o, 32'h200);
        chk("t4_rdata", rdata_o, 32'h22220013);
        if (glog.size() > 0) chk("t4_fetch0", glog[0], 32'h200);

        // Stall with ready low, then branch away.
        a0 = addr_o; d0 = rdata_o;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_valid", {31'd0, valid_o}, 1); chk("t5_addr", addr_o, a0); chk("t5_rdata", rdata_o, d0);
        end
        branch_to(32'h100);
        chk("t5_drop", {31'd0, valid_o}, 0);

        req_i = 0;
        repeat (10) step();
        chk("t6_idle_busy", {31'd0, busy_o}, 0);
        invalidate_i = 1; step(); invalidate_i = 0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin cnt += int'(busy_o); step(); end
        chk("t6_busy_cycles", cnt, 4);

        req_i = 1; min_dly = 3; max_dly = 3;
        branch_to(32'h200);
        for (int i = 0; i < 20 && glog.size() == 0; i++) step();
        #2 rst_n = 0;
        #1;
        chk("arst_valid", {31'd0, valid_o}, 0);   chk("arst_busy", {31'd0, busy_o}, 0);
        chk("arst_req", {31'd0, bus.req}, 0);     chk("arst_iaddr", bus.addr, 0);
        chk("arst_addr", addr_o, 0);              chk("arst_rdata", rdata_o, 0);
        chk("arst_err", {31'd0, err_o}, 0);       chk("arst_plus2", {31'd0, err_plus2_o}, 0);
        pend = 0;
        step(); step();
        rst_n = 1;
        step();

        // Random stream against the halfword model.
        for (int i = 0; i < 256; i++) begin mem_w[i] = $urandom; mem_e[i] = ($urandom_range(0, 15) == 0); end
        gnt_pct = 70; min_dly = 0; max_dly = 2; acc = 0;
        for (int b = 0; b < 40; b++) begin
            req_i = 1; ready_i = 0;
            pa = {22'd0, $urandom_range(0, 511), 1'b0};
            branch_to(pa);
            el = pa; done = 0; ph = 0;
            for (int c = 0; c < 60; c++) begin
                if (ph) begin
                    chk("rnd_hold_valid", {31'd0, valid_o}, 1);
                    chk("rnd_hold_addr", addr_o, pa);
                    chk("rnd_hold_rdata", {16'd0, rdata_o[15:0]}, {16'd0, pd[15:0]});
                end
                if (done) chk("rnd_after_err", {31'd0, valid_o}, 0);
                req_i   = ($urandom_range(0, 9) != 0);
                ready_i = $urandom_range(0, 1);
                branch_i = ($urandom_range(0, 29) == 0);
                branch_addr_i = {22'd0, $urandom_range(0, 511), 1'b0};
                if (valid_o && ready_i && !branch_i) begin
                    model(el, ed, em, ee, ep, cnt);
                    chk("rnd_addr", addr_o, el);
                    chk("rnd_rdata", rdata_o & em, ed);
                    chk("rnd_err", {31'd0, err_o}, {31'd0, ee});
                    chk("rnd_plus2", {31'd0, err_plus2_o}, {31'd0, ep});
                    el = el + cnt; acc++;
                    if (ee) done = 1;
                end
                ph = valid_o && !ready_i && !branch_i;
                pa = addr_o; pd = rdata_o;
                if (branch_i) begin el = branch_addr_i; done = 0; end
                step();
                branch_i = 0;
            end
        end
        chk("rnd_accepted", {31'd0, acc >= 40}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
